// File: rtl/data_break_if.sv
// data_break_if: break-cycle bus between the data-break controller and the
// processor state machine.
//   data_break  - break request, held until break_ack
//   db_to_disk  - break direction (1 = memory to device)
//   db_addr     - 15-bit break address (field + 12-bit address), bit 0 is MSB
//   db_wdata    - word written to memory by a device-to-memory break
//   break_ack   - one-cycle pulse: break cycle completed
//   mem_rdata   - memory word, valid in the break_ack cycle of a read break
// Handshake: a break cycle is consumed in exactly the clock cycle where
// data_break and break_ack are both high; the request side keeps all of its
// outputs stable from raising data_break until that cycle.
interface data_break_if;
  logic        data_break;
  logic        db_to_disk;
  logic [0:14] db_addr;
  logic [0:11] db_wdata;
  logic        break_ack;
  logic [0:11] mem_rdata;

  modport master (
    output data_break, db_to_disk, db_addr, db_wdata,
    input  break_ack, mem_rdata
  );

  modport slave (
    input  data_break, db_to_disk, db_addr, db_wdata,
    output break_ack, mem_rdata
  );
endinterface

// File: rtl/data_break_ctl.sv
// data_break_ctl: block-transfer controller that moves word_count words
// between a device and memory using processor data-break cycles.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   start, to_disk,       - transfer request and parameters, sampled in IDLE
//   start_addr, word_count  (word_count 0 means 4096 words)
//   abort                 - stop at the next safe point
//   dev_wdata/dev_valid/  - device-to-memory word source; dev_take pulses
//   dev_take                when the word is consumed
//   dev_rdata/dev_rvalid/ - memory-to-device word sink; a word is delivered
//   dev_ready               in the cycle dev_rvalid and dev_ready are high
//   brk                   - break-cycle bus (see data_break_if)
//   busy, done, aborted   - transfer status
//   dbg_state             - current FSM state encoding
module data_break_ctl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        to_disk,
  input  logic [0:14] start_addr,
  input  logic [0:11] word_count,
  input  logic        abort,
  input  logic [0:11] dev_wdata,
  input  logic        dev_valid,
  output logic        dev_take,
  output logic [0:11] dev_rdata,
  output logic        dev_rvalid,
  input  logic        dev_ready,
  data_break_if.master brk,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GET  = 3'd1,
    S_REQ  = 3'd2,
    S_PUT  = 3'd3,
    S_FIN  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [0:14] addr_q, addr_d;
  logic [0:11] cnt_q, cnt_d;
  logic        dir_q, dir_d;
  logic [0:11] wdata_q, wdata_d;
  logic [0:11] rdata_q, rdata_d;
  logic        aborted_q, aborted_d;
  logic        pend_q, pend_d;     // abort seen while a break cycle is open
  logic        take;
  logic        word_done;
  logic        last;

  // Remaining count is loaded raw; a load of 0 wraps to 4095 on the first
  // decrement, so reaching 0 again takes exactly 4096 words.
  assign last = (cnt_q == 12'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      aborted_q <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      aborted_q <= aborted_d;
      pend_q    <= pend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    aborted_d = aborted_q;
    pend_d    = pend_q;
    take      = 1'b0;
    word_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d    = start_addr;
          cnt_d     = word_count;
          dir_d     = to_disk;
          aborted_d = 1'b0;
          pend_d    = 1'b0;
          state_d   = to_disk ? S_REQ : S_GET;
        end
      end
      S_GET: begin
        // Abort wins over a word offered in the same cycle.
        if (abort) begin
          state_d   = S_FIN;
          aborted_d = 1'b1;
        end else if (dev_valid) begin
          take    = 1'b1;
          wdata_d = dev_wdata;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // An open break cycle is never abandoned; abort is remembered and
        // acted on once break_ack closes it.
        if (abort) pend_d = 1'b1;
        if (brk.break_ack) begin
          if (dir_q) begin
            rdata_d = brk.mem_rdata;
            if (abort || pend_q) begin
              state_d   = S_FIN;
              aborted_d = 1'b1;
            end else begin
              state_d = S_PUT;
            end
          end else begin
            word_done = 1'b1;
            if (last) begin
              state_d = S_FIN;
            end else if (abort || pend_q) begin
              state_d   = S_FIN;
              aborted_d = 1'b1;
            end else begin
              state_d = S_GET;
            end
          end
        end
      end
      S_PUT: begin
        if (dev_ready) begin
          word_done = 1'b1;
          if (last) begin
            state_d = S_FIN;
          end else if (abort) begin
            state_d   = S_FIN;
            aborted_d = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end else if (abort) begin
          state_d   = S_FIN;
          aborted_d = 1'b1;
        end
      end
      S_FIN: begin
        pend_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Address wraps naturally modulo 2^15, carrying into the field bits.
    if (word_done) begin
      addr_d = addr_q + 15'd1;
      cnt_d  = cnt_q - 12'd1;
    end
  end

  assign dev_take       = take;
  assign dev_rdata      = rdata_q;
  assign dev_rvalid     = (state_q == S_PUT);
  assign brk.data_break = (state_q == S_REQ);
  assign brk.db_to_disk = dir_q;
  assign brk.db_addr    = addr_q;
  assign brk.db_wdata   = wdata_q;
  // busy drops in the FIN cycle so it is already low while done pulses.
  assign busy           = (state_q == S_GET) || (state_q == S_REQ) ||
                          (state_q == S_PUT);
  assign done           = (state_q == S_FIN);
  assign aborted        = aborted_q;
  assign dbg_state      = state_q;

endmodule
